pe_feeder: RTL and testbench

Sequencer that drives one parallel PE dot-product lane from its neuron and weight buffers and collects the result. For each command it reads `len` consecutive 512-bit beats from both buffers and streams them contiguously to the PE, framing them with the first/last control bits. It then captures the single-cycle PE result and holds it on a ready/valid output port. It sits between the buffer controllers and the PE array.

---
 rtl/pe_feeder_pkg.sv | 22 ++
 rtl/pe_feeder_rd_pipe.sv | 72 +++++++
 rtl/pe_feeder.sv | 167 ++++++++++++++++
 tb/tb_pe_feeder.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_feeder_pkg.sv
// pe_feeder_pkg
// Shared definitions for the PE feeder: sequencer state encoding,
// pe_ctl bit positions and default interface widths.
package pe_feeder_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 512;
    localparam int RES_W_DEF  = 32;

    // Bit positions inside pe_ctl
    localparam int CTL_FIRST = 0;
    localparam int CTL_LAST  = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_OUT      = 3'd4
    } state_t;

endpackage

// File: rtl/pe_feeder_rd_pipe.sv
// pe_feeder_rd_pipe
// Carries beat framing (valid, first, last) alongside the buffer read
// latency and registers the returned operands before they reach the PE.
// This is the only source of the pe_* outputs.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   i_rd_en           - read strobe issued to both buffers this cycle
//   i_first, i_last   - framing flags belonging to that read
//   i_nbuf_rdata      - neuron buffer data (1 cycle after strobe)
//   i_wbuf_rdata      - weight buffer data (1 cycle after strobe)
//   o_pe_neuron/weight- registered operands
//   o_pe_ctl          - {last, first}, zero whenever o_pe_vld is low
//   o_pe_vld          - beat valid, 2 cycles after the read strobe
module pe_feeder_rd_pipe
    import pe_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd_en,
    input  logic              i_first,
    input  logic              i_last,
    input  logic [DATA_W-1:0] i_nbuf_rdata,
    input  logic [DATA_W-1:0] i_wbuf_rdata,
    output logic [DATA_W-1:0] o_pe_neuron,
    output logic [DATA_W-1:0] o_pe_weight,
    output logic [1:0]        o_pe_ctl,
    output logic              o_pe_vld
);

    // Stage 1: aligned with the buffer's read latency
    logic r_s1_vld;
    logic r_s1_first;
    logic r_s1_last;

    // Stage 2: registered operands presented to the PE
    logic              r_vld;
    logic [1:0]        r_ctl;
    logic [DATA_W-1:0] r_neuron;
    logic [DATA_W-1:0] r_weight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_vld      <= 1'b0;
            r_ctl      <= 2'b00;
            r_neuron   <= '0;
            r_weight   <= '0;
        end else begin
            r_s1_vld   <= i_rd_en;
            r_s1_first <= i_rd_en & i_first;
            r_s1_last  <= i_rd_en & i_last;
            r_vld      <= r_s1_vld;
            // Gate with valid so the PE never sees a stray last bit
            r_ctl[CTL_FIRST] <= r_s1_vld & r_s1_first;
            r_ctl[CTL_LAST]  <= r_s1_vld & r_s1_last;
            if (r_s1_vld) begin
                r_neuron <= i_nbuf_rdata;
                r_weight <= i_wbuf_rdata;
            end
        end
    end

    assign o_pe_vld    = r_vld;
    assign o_pe_ctl    = r_ctl;
    assign o_pe_neuron = r_neuron;
    assign o_pe_weight = r_weight;

endmodule

// File: rtl/pe_feeder.sv
// pe_feeder
// Sequences one dot-product command: reads len beats from the neuron and
// weight buffers, streams them framed to the PE, captures the PE result
// and holds it on a ready/valid port. One command in flight at a time.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   i_cmd_vld / o_cmd_rdy       - command handshake (ready only in IDLE)
//   i_cmd_n_base, i_cmd_w_base  - buffer start addresses
//   i_cmd_len                   - beat count, 0 allowed
//   o_nbuf_*/o_wbuf_*           - buffer read strobes and addresses
//   i_nbuf_rdata, i_wbuf_rdata  - buffer read data
//   o_pe_neuron/weight/ctl/vld  - PE beat stream
//   i_pe_result, i_pe_vld_o     - PE result
//   o_res_vld/i_res_rdy/o_res_data - result handshake
//   o_busy                      - high when not IDLE
module pe_feeder
    import pe_feeder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_vld,
    output logic              o_cmd_rdy,
    input  logic [ADDR_W-1:0] i_cmd_n_base,
    input  logic [ADDR_W-1:0] i_cmd_w_base,
    input  logic [ADDR_W-1:0] i_cmd_len,
    output logic              o_nbuf_rd_en,
    output logic              o_wbuf_rd_en,
    output logic [ADDR_W-1:0] o_nbuf_addr,
    output logic [ADDR_W-1:0] o_wbuf_addr,
    input  logic [DATA_W-1:0] i_nbuf_rdata,
    input  logic [DATA_W-1:0] i_wbuf_rdata,
    output logic [DATA_W-1:0] o_pe_neuron,
    output logic [DATA_W-1:0] o_pe_weight,
    output logic [1:0]        o_pe_ctl,
    output logic              o_pe_vld,
    input  logic [RES_W-1:0]  i_pe_result,
    input  logic              i_pe_vld_o,
    output logic              o_res_vld,
    input  logic              i_res_rdy,
    output logic [RES_W-1:0]  o_res_data,
    output logic              o_busy
);

    state_t            r_state;
    logic              r_rd_en;
    logic              r_first;
    logic              r_last;
    logic [ADDR_W-1:0] r_n_addr;
    logic [ADDR_W-1:0] r_w_addr;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_res_vld;
    logic [RES_W-1:0]  r_res_data;

    logic [ADDR_W-1:0] w_cnt_inc;
    logic              w_pe_vld;
    logic [1:0]        w_pe_ctl;
    logic              w_last_out;

    assign w_cnt_inc  = r_cnt + ADDR_W'(1);
    // The last beat is on the PE port this cycle; its result follows next cycle
    assign w_last_out = w_pe_vld & w_pe_ctl[CTL_LAST];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rd_en    <= 1'b0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
            r_n_addr   <= '0;
            r_w_addr   <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_res_vld  <= 1'b0;
            r_res_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_vld) begin
                        r_n_addr <= i_cmd_n_base;
                        r_w_addr <= i_cmd_w_base;
                        r_len    <= i_cmd_len;
                        r_cnt    <= '0;
                        if (i_cmd_len == '0) begin
                            r_res_data <= '0;
                            r_res_vld  <= 1'b1;
                            r_state    <= ST_OUT;
                        end else begin
                            r_rd_en <= 1'b1;
                            r_first <= 1'b1;
                            r_last  <= (i_cmd_len == ADDR_W'(1));
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (r_last) begin
                        r_rd_en <= 1'b0;
                        r_first <= 1'b0;
                        r_last  <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        // Address increment wraps naturally at 2^ADDR_W
                        r_cnt    <= w_cnt_inc;
                        r_n_addr <= r_n_addr + ADDR_W'(1);
                        r_w_addr <= r_w_addr + ADDR_W'(1);
                        r_first  <= 1'b0;
                        r_last   <= (w_cnt_inc == r_len - ADDR_W'(1));
                    end
                end
                ST_DRAIN: begin
                    if (w_last_out) begin
                        r_state <= ST_WAIT_RES;
                    end
                end
                ST_WAIT_RES: begin
                    if (i_pe_vld_o) begin
                        r_res_data <= i_pe_result;
                        r_res_vld  <= 1'b1;
                        r_state    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (i_res_rdy) begin
                        r_res_vld <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    pe_feeder_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk          (clk),
        .rst          (rst),
        .i_rd_en      (r_rd_en),
        .i_first      (r_first),
        .i_last       (r_last),
        .i_nbuf_rdata (i_nbuf_rdata),
        .i_wbuf_rdata (i_wbuf_rdata),
        .o_pe_neuron  (o_pe_neuron),
        .o_pe_weight  (o_pe_weight),
        .o_pe_ctl     (w_pe_ctl),
        .o_pe_vld     (w_pe_vld)
    );

    assign o_pe_vld     = w_pe_vld;
    assign o_pe_ctl     = w_pe_ctl;
    assign o_cmd_rdy    = (r_state == ST_IDLE);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_nbuf_rd_en = r_rd_en;
    assign o_wbuf_rd_en = r_rd_en;
    assign o_nbuf_addr  = r_n_addr;
    assign o_wbuf_addr  = r_w_addr;
    assign o_res_vld    = r_res_vld;
    assign o_res_data   = r_res_data;

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder
// Drives pe_feeder with buffer and PE models and compares the observed
// read, beat and result traces against expectations derived from the
// command fields and buffer contents.
module tb_pe_feeder;

    localparam int AW    = 8;
    localparam int DW    = 512;
    localparam int RW    = 32;
    localparam int LANES = DW / 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_vld = 1'b0;
    logic          cmd_rdy;
    logic [AW-1:0] cmd_n_base = '0;
    logic [AW-1:0] cmd_w_base = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          nbuf_rd_en, wbuf_rd_en;
    logic [AW-1:0] nbuf_addr, wbuf_addr;
    logic [DW-1:0] nbuf_rdata = '0;
    logic [DW-1:0] wbuf_rdata = '0;
    logic [DW-1:0] pe_neuron, pe_weight;
    logic [1:0]    pe_ctl;
    logic          pe_vld;
    logic [RW-1:0] pe_result;
    logic          pe_vld_o;
    logic          res_vld;
    logic          res_rdy = 1'b0;
    logic [RW-1:0] res_data;
    logic          busy;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .i_cmd_vld    (cmd_vld),
        .o_cmd_rdy    (cmd_rdy),
        .i_cmd_n_base (cmd_n_base),
        .i_cmd_w_base (cmd_w_base),
        .i_cmd_len    (cmd_len),
        .o_nbuf_rd_en (nbuf_rd_en),
        .o_wbuf_rd_en (wbuf_rd_en),
        .o_nbuf_addr  (nbuf_addr),
        .o_wbuf_addr  (wbuf_addr),
        .i_nbuf_rdata (nbuf_rdata),
        .i_wbuf_rdata (wbuf_rdata),
        .o_pe_neuron  (pe_neuron),
        .o_pe_weight  (pe_weight),
        .o_pe_ctl     (pe_ctl),
        .o_pe_vld     (pe_vld),
        .i_pe_result  (pe_result),
        .i_pe_vld_o   (pe_vld_o),
        .o_res_vld    (res_vld),
        .i_res_rdy    (res_rdy),
        .o_res_data   (res_data),
        .o_busy       (busy)
    );

    // Buffer models: one-cycle registered read
    logic [DW-1:0] nmem [256];
    logic [DW-1:0] wmem [256];
    always @(posedge clk) begin
        if (nbuf_rd_en) nbuf_rdata <= nmem[nbuf_addr];
        if (wbuf_rd_en) wbuf_rdata <= wmem[wbuf_addr];
    end

    // 16 lanes of 32-bit products, summed modulo 2^32
    function automatic logic [31:0] row_dot(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [31:0] s = 32'd0;
        for (int j = 0; j < LANES; j++) s += a[j*32 +: 32] * b[j*32 +: 32];
        return s;
    endfunction

    function automatic logic [31:0] golden(input logic [7:0] nb, input logic [7:0] wb, input logic [7:0] ln);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < int'(ln); i++) s += row_dot(nmem[8'(nb + i)], wmem[8'(wb + i)]);
        return s;
    endfunction

    // PE model: accumulates framed beats, clears on idle, fires on ctl[1]
    logic [31:0] pe_acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_acc    <= 32'd0;
            pe_vld_o  <= 1'b0;
            pe_result <= 32'd0;
        end else begin
            pe_vld_o <= 1'b0;
            if (pe_vld) begin
                pe_acc <= (pe_ctl[0] ? 32'd0 : pe_acc) + row_dot(pe_neuron, pe_weight);
                if (pe_ctl[1]) begin
                    pe_vld_o  <= 1'b1;
                    pe_result <= (pe_ctl[0] ? 32'd0 : pe_acc) + row_dot(pe_neuron, pe_weight);
                end
            end else begin
                pe_acc <= 32'd0;
            end
        end
    end

    // Event logs, only ever appended by the monitor
    int            acc_q[$];
    int            rd_cyc[$];
    logic [7:0]    rd_na[$];
    logic [7:0]    rd_wa[$];
    int            beat_cyc[$];
    logic [1:0]    beat_ctl[$];
    logic [DW-1:0] beat_n[$];
    logic [DW-1:0] beat_w[$];
    int            res_q[$];
    logic [31:0]   resv_q[$];
    int            hs_q[$];
    int            skew = 0;
    int            stray = 0;
    int            res_chg = 0;
    int            rdy_in_out = 0;
    logic          res_prev = 1'b0;
    logic [31:0]   res_hold = 32'd0;

    always @(negedge clk) begin
        if (cmd_vld && cmd_rdy) acc_q.push_back(cyc);
        if (nbuf_rd_en || wbuf_rd_en) begin
            rd_cyc.push_back(cyc);
            rd_na.push_back(nbuf_addr);
            rd_wa.push_back(wbuf_addr);
            if (nbuf_rd_en != wbuf_rd_en) skew <= skew + 1;
        end
        if (pe_vld) begin
            beat_cyc.push_back(cyc);
            beat_ctl.push_back(pe_ctl);
            beat_n.push_back(pe_neuron);
            beat_w.push_back(pe_weight);
        end else if (pe_ctl != 2'b00) begin
            stray <= stray + 1;
        end
        if (res_vld && !res_prev) begin
            res_q.push_back(cyc);
            resv_q.push_back(res_data);
        end else if (res_vld && res_data != res_hold) begin
            res_chg <= res_chg + 1;
        end
        if (res_vld && cmd_rdy) rdy_in_out <= rdy_in_out + 1;
        if (res_vld && res_rdy) hs_q.push_back(cyc);
        res_prev <= res_vld;
        res_hold <= res_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue a command, wait for its result, hold res_rdy low for 'hold'
    // extra cycles, then complete the handshake. Called at posedge+1.
    task automatic run_cmd(input logic [7:0] nb, input logic [7:0] wb, input logic [7:0] ln, input int hold);
        int  n;
        bit  got;
        cmd_n_base = nb;
        cmd_w_base = wb;
        cmd_len    = ln;
        cmd_vld    = 1'b1;
        got = 1'b0;
        n   = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            got = cmd_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        cmd_vld = 1'b0;
        cmp_cnt++;
        if (!got) begin
            err_cnt++;
            $display("FAIL cmd_accept: cmd_rdy never high, got 0 required 1");
            return;
        end
        got = 1'b0;
        n   = 0;
        while (!got && n < 400) begin
            @(negedge clk);
            got = res_vld;
            n++;
        end
        cmp_cnt++;
        if (!got) begin
            err_cnt++;
            $display("FAIL res_timeout: res_vld never rose, got 0 required 1");
            return;
        end
        @(posedge clk);
        #1;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        res_rdy = 1'b1;
        @(posedge clk);
        #1;
        res_rdy = 1'b0;
        $display("cmd n_base=%02h w_base=%02h len=%0d hold=%0d res_data=%08h", nb, wb, ln, hold, res_data);
    endtask

    task automatic test_reset;
        #1;
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b required 0", busy); end
        cmp_cnt++; if (pe_vld !== 1'b0 || pe_ctl !== 2'b00) begin err_cnt++; $display("FAIL reset_pe: vld %b ctl %b required 0 00", pe_vld, pe_ctl); end
        cmp_cnt++; if (nbuf_rd_en !== 1'b0 || wbuf_rd_en !== 1'b0) begin err_cnt++; $display("FAIL reset_strobe: got %b%b required 00", nbuf_rd_en, wbuf_rd_en); end
        cmp_cnt++; if (nbuf_addr !== 8'h00 || wbuf_addr !== 8'h00) begin err_cnt++; $display("FAIL reset_addr: got %h %h required 00 00", nbuf_addr, wbuf_addr); end
        cmp_cnt++; if (res_vld !== 1'b0 || res_data !== 32'd0) begin err_cnt++; $display("FAIL reset_res: vld %b data %h required 0 0", res_vld, res_data); end
        cmp_cnt++; if (pe_neuron !== '0 || pe_weight !== '0) begin err_cnt++; $display("FAIL reset_operands: nonzero low words %h %h", pe_neuron[31:0], pe_weight[31:0]); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        cmp_cnt++; if (cmd_rdy !== 1'b1) begin err_cnt++; $display("FAIL reset_cmd_rdy: got %b required 1", cmd_rdy); end
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_len1;
        int r0, b0, a0, q0, c0;
        nmem[8'h10] = '0;
        nmem[8'h10][31:0] = 32'h0000_00AB;
        wmem[8'h20] = '0;
        wmem[8'h20][31:0] = 32'h0000_0001;
        r0 = rd_cyc.size(); b0 = beat_cyc.size(); a0 = acc_q.size(); q0 = res_q.size();
        run_cmd(8'h10, 8'h20, 8'd1, 0);
        if (acc_q.size() <= a0 || res_q.size() <= q0) return;
        c0 = acc_q[a0];
        cmp_cnt++; if (rd_cyc.size() - r0 != 1) begin err_cnt++; $display("FAIL len1_reads: got %0d required 1", rd_cyc.size() - r0); end
        else begin
            cmp_cnt++;
            if (rd_cyc[r0] != c0 + 1 || rd_na[r0] !== 8'h10 || rd_wa[r0] !== 8'h20) begin
                err_cnt++; $display("FAIL len1_read: cyc %0d addr %h/%h required cyc %0d addr 10/20", rd_cyc[r0] - c0, rd_na[r0], rd_wa[r0], 1);
            end
        end
        cmp_cnt++; if (beat_cyc.size() - b0 != 1) begin err_cnt++; $display("FAIL len1_beats: got %0d required 1", beat_cyc.size() - b0); end
        else begin
            cmp_cnt++;
            if (beat_ctl[b0] !== 2'b11 || beat_cyc[b0] != c0 + 3) begin
                err_cnt++; $display("FAIL len1_beat: ctl %b at cycle %0d required 11 at cycle 3", beat_ctl[b0], beat_cyc[b0] - c0);
            end
        end
        cmp_cnt++; if (res_q[q0] != c0 + 5) begin err_cnt++; $display("FAIL len1_res_cycle: got %0d required 5", res_q[q0] - c0); end
        cmp_cnt++; if (resv_q[q0] !== 32'h0000_00AB) begin err_cnt++; $display("FAIL len1_res_data: got %h required 000000ab", resv_q[q0]); end
    endtask

    task automatic test_len4_ascending;
        logic [1:0] exp_ctl [4] = '{2'b01, 2'b00, 2'b00, 2'b10};
        int r0, b0, a0, q0, c0;
        for (int i = 0; i < 4; i++) begin
            nmem[8'(8'h40 + i)] = {LANES{32'(i + 1)}};
            wmem[8'(8'h80 + i)] = {LANES{32'(i + 1)}};
        end
        r0 = rd_cyc.size(); b0 = beat_cyc.size(); a0 = acc_q.size(); q0 = res_q.size();
        run_cmd(8'h40, 8'h80, 8'd4, 1);
        if (acc_q.size() <= a0 || res_q.size() <= q0) return;
        c0 = acc_q[a0];
        cmp_cnt++; if (rd_cyc.size() - r0 != 4 || beat_cyc.size() - b0 != 4) begin
            err_cnt++; $display("FAIL len4_counts: reads %0d beats %0d required 4 4", rd_cyc.size() - r0, beat_cyc.size() - b0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                cmp_cnt++;
                if (rd_na[r0+i] !== 8'(8'h40 + i) || rd_wa[r0+i] !== 8'(8'h80 + i)) begin
                    err_cnt++; $display("FAIL len4_addr%0d: got %h/%h required %h/%h", i, rd_na[r0+i], rd_wa[r0+i], 8'(8'h40 + i), 8'(8'h80 + i));
                end
                cmp_cnt++;
                if (beat_ctl[b0+i] !== exp_ctl[i] || beat_cyc[b0+i] != c0 + 3 + i) begin
                    err_cnt++; $display("FAIL len4_beat%0d: ctl %b cycle %0d required ctl %b cycle %0d", i, beat_ctl[b0+i], beat_cyc[b0+i] - c0, exp_ctl[i], 3 + i);
                end
            end
        end
        cmp_cnt++; if (resv_q[q0] !== 32'd480) begin err_cnt++; $display("FAIL len4_result: got %0d required 480", resv_q[q0]); end
        cmp_cnt++; if (res_q[q0] != c0 + 8) begin err_cnt++; $display("FAIL len4_res_cycle: got %0d required 8", res_q[q0] - c0); end
    endtask

    task automatic test_addr_wrap;
        logic [7:0] exp_na [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        int r0, q0;
        r0 = rd_cyc.size(); q0 = res_q.size();
        run_cmd(8'hFE, 8'h03, 8'd4, 0);
        cmp_cnt++; if (rd_cyc.size() - r0 != 4) begin
            err_cnt++; $display("FAIL wrap_reads: got %0d required 4", rd_cyc.size() - r0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                cmp_cnt++;
                if (rd_na[r0+i] !== exp_na[i]) begin
                    err_cnt++; $display("FAIL wrap_addr%0d: got %h required %h", i, rd_na[r0+i], exp_na[i]);
                end
            end
        end
        if (res_q.size() > q0) begin
            cmp_cnt++;
            if (resv_q[q0] !== golden(8'hFE, 8'h03, 8'd4)) begin
                err_cnt++; $display("FAIL wrap_result: got %h required %h", resv_q[q0], golden(8'hFE, 8'h03, 8'd4));
            end
        end
    endtask

    task automatic test_zero_len;
        int r0, b0, a0, q0, c0;
        r0 = rd_cyc.size(); b0 = beat_cyc.size(); a0 = acc_q.size(); q0 = res_q.size();
        run_cmd(8'h55, 8'h66, 8'd0, 2);
        if (acc_q.size() <= a0 || res_q.size() <= q0) return;
        c0 = acc_q[a0];
        cmp_cnt++; if (rd_cyc.size() != r0) begin err_cnt++; $display("FAIL zero_reads: got %0d required 0", rd_cyc.size() - r0); end
        cmp_cnt++; if (beat_cyc.size() != b0) begin err_cnt++; $display("FAIL zero_beats: got %0d required 0", beat_cyc.size() - b0); end
        cmp_cnt++; if (res_q[q0] != c0 + 1) begin err_cnt++; $display("FAIL zero_res_cycle: got %0d required 1", res_q[q0] - c0); end
        cmp_cnt++; if (resv_q[q0] !== 32'd0) begin err_cnt++; $display("FAIL zero_res_data: got %h required 0", resv_q[q0]); end
    endtask

    task automatic test_backpressure;
        int chg0, rio0, q0, h0, a0, b0;
        logic [7:0] nb, wb, nb2, wb2;
        nb = 8'($urandom); wb = 8'($urandom); nb2 = 8'($urandom); wb2 = 8'($urandom);
        chg0 = res_chg; rio0 = rdy_in_out;
        q0 = res_q.size(); h0 = hs_q.size(); a0 = acc_q.size(); b0 = beat_cyc.size();
        run_cmd(nb, wb, 8'd3, 10);
        run_cmd(nb2, wb2, 8'd2, 0);
        cmp_cnt++;
        if (hs_q.size() < h0 + 2 || res_q.size() < q0 + 2 || acc_q.size() < a0 + 2 || beat_cyc.size() < b0 + 5) begin
            err_cnt++; $display("FAIL bp_events: hs %0d res %0d acc %0d beats %0d required 2 2 2 5",
                                hs_q.size() - h0, res_q.size() - q0, acc_q.size() - a0, beat_cyc.size() - b0);
            return;
        end
        cmp_cnt++; if (res_chg != chg0) begin err_cnt++; $display("FAIL bp_stable: res_data changed %0d times required 0", res_chg - chg0); end
        cmp_cnt++; if (rdy_in_out != rio0) begin err_cnt++; $display("FAIL bp_cmd_rdy: high %0d cycles during OUT required 0", rdy_in_out - rio0); end
        cmp_cnt++; if (hs_q[h0] - res_q[q0] != 11) begin err_cnt++; $display("FAIL bp_hold: handshake after %0d cycles required 11", hs_q[h0] - res_q[q0]); end
        cmp_cnt++; if (acc_q[a0+1] != hs_q[h0] + 1) begin err_cnt++; $display("FAIL bp_next_accept: %0d cycles after handshake required 1", acc_q[a0+1] - hs_q[h0]); end
        cmp_cnt++; if (beat_cyc[b0+3] - beat_cyc[b0+2] - 1 < 2) begin err_cnt++; $display("FAIL bp_gap: got %0d low cycles required >=2", beat_cyc[b0+3] - beat_cyc[b0+2] - 1); end
        cmp_cnt++; if (resv_q[q0] !== golden(nb, wb, 8'd3)) begin err_cnt++; $display("FAIL bp_res1: got %h required %h", resv_q[q0], golden(nb, wb, 8'd3)); end
        cmp_cnt++; if (resv_q[q0+1] !== golden(nb2, wb2, 8'd2)) begin err_cnt++; $display("FAIL bp_res2: got %h required %h", resv_q[q0+1], golden(nb2, wb2, 8'd2)); end
    endtask

    task automatic test_reset_mid;
        int b0, q0, r0, a0, n, c0;
        logic [7:0] nb, wb;
        nb = 8'($urandom); wb = 8'($urandom);
        b0 = beat_cyc.size(); q0 = res_q.size();
        cmd_n_base = nb; cmd_w_base = wb; cmd_len = 8'd8; cmd_vld = 1'b1;
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        n = 0;
        while (beat_cyc.size() < b0 + 3 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        cmp_cnt++;
        if (beat_cyc.size() < b0 + 3) begin
            err_cnt++; $display("FAIL rstmid_beats: got %0d beats required 3", beat_cyc.size() - b0);
        end
        rst = 1'b1;
        #1;
        cmp_cnt++; if (pe_vld !== 1'b0 || pe_ctl !== 2'b00) begin err_cnt++; $display("FAIL rstmid_pe: vld %b ctl %b required 0 00", pe_vld, pe_ctl); end
        cmp_cnt++; if (res_vld !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_res: res_vld %b busy %b required 0 0", res_vld, busy); end
        cmp_cnt++; if (nbuf_rd_en !== 1'b0) begin err_cnt++; $display("FAIL rstmid_strobe: got %b required 0", nbuf_rd_en); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cmp_cnt++; if (cmd_rdy !== 1'b1 || res_q.size() != q0) begin
            err_cnt++; $display("FAIL rstmid_idle: cmd_rdy %b results %0d required 1 0", cmd_rdy, res_q.size() - q0);
        end
        nb = 8'($urandom); wb = 8'($urandom);
        r0 = rd_cyc.size(); b0 = beat_cyc.size(); a0 = acc_q.size(); q0 = res_q.size();
        run_cmd(nb, wb, 8'd2, 0);
        if (acc_q.size() <= a0 || res_q.size() <= q0) return;
        c0 = acc_q[a0];
        cmp_cnt++; if (rd_cyc.size() - r0 != 2 || beat_cyc.size() - b0 != 2) begin
            err_cnt++; $display("FAIL rstmid_counts: reads %0d beats %0d required 2 2", rd_cyc.size() - r0, beat_cyc.size() - b0);
        end else begin
            cmp_cnt++; if (beat_ctl[b0] !== 2'b01 || beat_ctl[b0+1] !== 2'b10) begin
                err_cnt++; $display("FAIL rstmid_ctl: got %b %b required 01 10", beat_ctl[b0], beat_ctl[b0+1]);
            end
        end
        cmp_cnt++; if (res_q[q0] != c0 + 6 || resv_q[q0] !== golden(nb, wb, 8'd2)) begin
            err_cnt++; $display("FAIL rstmid_result: cycle %0d data %h required cycle 6 data %h", res_q[q0] - c0, resv_q[q0], golden(nb, wb, 8'd2));
        end
    endtask

    task automatic test_random;
        for (int t = 0; t < 25; t++) begin
            logic [7:0]  nb, wb, ln, ea, eb;
            logic [1:0]  ec;
            logic [31:0] ev;
            int          hold, r0, b0, a0, q0, c0, nr, nbt, ecyc;
            nb = 8'($urandom); wb = 8'($urandom); ln = 8'($urandom_range(0, 12));
            hold = $urandom_range(0, 3);
            r0 = rd_cyc.size(); b0 = beat_cyc.size(); a0 = acc_q.size(); q0 = res_q.size();
            run_cmd(nb, wb, ln, hold);
            if (acc_q.size() <= a0 || res_q.size() <= q0) continue;
            c0  = acc_q[a0];
            nr  = rd_cyc.size() - r0;
            nbt = beat_cyc.size() - b0;
            cmp_cnt++;
            if (nr != int'(ln) || nbt != int'(ln)) begin
                err_cnt++; $display("FAIL rand%0d_counts: reads %0d beats %0d required %0d", t, nr, nbt, ln);
            end
            for (int i = 0; i < int'(ln) && i < nr; i++) begin
                ea = 8'(nb + i); eb = 8'(wb + i);
                cmp_cnt++;
                if (rd_cyc[r0+i] != c0 + 1 + i || rd_na[r0+i] !== ea || rd_wa[r0+i] !== eb) begin
                    err_cnt++; $display("FAIL rand%0d_read%0d: cycle %0d addr %h/%h required cycle %0d addr %h/%h",
                                        t, i, rd_cyc[r0+i] - c0, rd_na[r0+i], rd_wa[r0+i], 1 + i, ea, eb);
                end
            end
            for (int i = 0; i < int'(ln) && i < nbt; i++) begin
                ea = 8'(nb + i); eb = 8'(wb + i);
                ec = {(i == int'(ln) - 1), (i == 0)};
                cmp_cnt++;
                if (beat_cyc[b0+i] != c0 + 3 + i || beat_ctl[b0+i] !== ec ||
                    beat_n[b0+i] !== nmem[ea] || beat_w[b0+i] !== wmem[eb]) begin
                    err_cnt++; $display("FAIL rand%0d_beat%0d: cycle %0d ctl %b n %h w %h required cycle %0d ctl %b n %h w %h",
                                        t, i, beat_cyc[b0+i] - c0, beat_ctl[b0+i], beat_n[b0+i][31:0], beat_w[b0+i][31:0],
                                        3 + i, ec, nmem[ea][31:0], wmem[eb][31:0]);
                end
            end
            ecyc = (ln == 8'd0) ? c0 + 1 : c0 + int'(ln) + 4;
            ev   = golden(nb, wb, ln);
            cmp_cnt++;
            if (res_q[q0] != ecyc || resv_q[q0] !== ev) begin
                err_cnt++; $display("FAIL rand%0d_result: cycle %0d data %h required cycle %0d data %h",
                                    t, res_q[q0] - c0, resv_q[q0], ecyc - c0, ev);
            end
        end
        cmp_cnt++; if (stray != 0) begin err_cnt++; $display("FAIL stray_ctl: %0d cycles with ctl set and vld low, required 0", stray); end
        cmp_cnt++; if (skew != 0) begin err_cnt++; $display("FAIL strobe_skew: %0d cycles with unequal strobes, required 0", skew); end
    endtask

    initial begin
        for (int r = 0; r < 256; r++) begin
            for (int j = 0; j < LANES; j++) begin
                nmem[r][j*32 +: 32] = $urandom;
                wmem[r][j*32 +: 32] = $urandom;
            end
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        test_reset;
        test_len1;
        test_len4_ascending;
        test_addr_wrap;
        test_zero_len;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
